regfile_dump: RTL

Read-out sequencer for the CPU register file. On a `Start` pulse it walks registers 0..NUM_REGS-1 two at a time through the register file's two combinational read ports. Each value is emitted as one word on a valid/ready stream, tagged with its register index. It sits beside the register file as its read-side initiator and serves debug/trace logic. Optionally it zeroes each register after reading it, using the register file's write port.

---
 rtl/regfile_dump.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// Register-file dump sequencer: walks registers in pairs through two read ports and streams each value tagged with its index.
// Optional clear-after-read (macro REGFILE_DUMP_CLEAR_EN) zeroes every dumped register through the write port.
module regfile_dump #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  rn1_o,
    output logic [4:0]  rn2_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        write_o,
    output logic [4:0]  wn_o,
    output logic [31:0] wd_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [4:0]  out_index_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CAPT  = 3'd2,
        SEND0 = 3'd3,
        SEND1 = 3'd4,
        DONE  = 3'd5
`ifdef REGFILE_DUMP_CLEAR_EN
        , CLR1 = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] ha_q, ha_d;
    logic [31:0] hb_q, hb_d;
    logic        last_pair;

    // Widened compare so NUM_REGS=32 does not wrap the 5-bit index.
    assign last_pair = ({1'b0, idx_q} + 6'd2) == 6'(NUM_REGS);

    assign rn1_o = idx_q;
    assign rn2_o = idx_q + 5'd1;
    assign wd_o  = 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            ha_q    <= 32'd0;
            hb_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ha_d        = ha_q;
        hb_d        = hb_q;
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        write_o     = 1'b0;
        wn_o        = 5'd0;
        out_valid_o = 1'b0;
        out_data_o  = 32'd0;
        out_index_o = 5'd0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d   = 5'd0;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = CAPT;
            CAPT: begin
                // Capture and the optional clear commit on the same edge, so the pre-clear value is held.
                ha_d = a_i;
                hb_d = b_i;
`ifdef REGFILE_DUMP_CLEAR_EN
                write_o = 1'b1;
                wn_o    = idx_q;
                state_d = CLR1;
`else
                state_d = SEND0;
`endif
            end
`ifdef REGFILE_DUMP_CLEAR_EN
            CLR1: begin
                write_o = 1'b1;
                wn_o    = idx_q + 5'd1;
                state_d = SEND0;
            end
`endif
            SEND0: begin
                out_valid_o = 1'b1;
                out_data_o  = ha_q;
                out_index_o = idx_q;
                if (out_ready_i) state_d = SEND1;
            end
            SEND1: begin
                out_valid_o = 1'b1;
                out_data_o  = hb_q;
                out_index_o = idx_q + 5'd1;
                if (out_ready_i) begin
                    if (last_pair) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd2;
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                idx_d   = 5'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
